priority_grant_decoder: RTL

Consumer end of the 4-to-2 priority encoder interface. Accepts an encoded index plus valid (the encoder's out/valid pair) and decodes it back to a registered one-hot grant. Holds the grant until the granted lane signals done or a hold timer expires, then enforces a one-cycle dead gap before accepting the next index. Sits between the priority encoder and the requesting lanes, and turns the encoder's combinational result into a sequenced, exclusive grant.

---
 rtl/prio_dec_pkg.sv | 21 ++
 rtl/priority_grant_decoder_hold_timer.sv | 35 +++
 rtl/priority_grant_decoder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/prio_dec_pkg.sv
// Shared types and helpers for the priority grant decoder.
package prio_dec_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StGap   = 2'd2
  } state_e;

  // Decode is sized wider than any supported lane count; callers keep the low N bits.
  localparam int unsigned MaxIdxW  = 6;
  localparam int unsigned MaxLanes = 2 ** MaxIdxW;

  function automatic logic [MaxLanes-1:0] onehot_decode(input logic [MaxIdxW-1:0] idx);
    logic [MaxLanes-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/priority_grant_decoder_hold_timer.sv
// Grant hold counter: counts cycles while enabled, flags the last allowed grant cycle.
module hold_timer #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      // Saturate rather than wrap; only reachable when the timeout is disabled.
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (MAX_HOLD != 0) && (count_q == CNT_W'(MAX_HOLD - 1));

endmodule

// File: rtl/priority_grant_decoder.sv
// Turns an encoded index/valid pair into a held, exclusive one-hot grant with
// done/timeout release and a one-cycle dead gap between grants.
module priority_grant_decoder
  import prio_dec_pkg::*;
#(
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned TO_CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [IDX_W-1:0]    in_idx,
  output logic                in_ready,
  input  logic [2**IDX_W-1:0] done,
  output logic [2**IDX_W-1:0] grant,
  output logic                grant_valid,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                timeout,
  output logic                busy,
  output logic [TO_CNT_W-1:0] timeout_cnt
);

  localparam int unsigned N = 2 ** IDX_W;

  state_e              state_q, state_d;
  logic [N-1:0]        grant_q, grant_d;
  logic                grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic                timeout_q, timeout_d;
  logic                busy_q, busy_d;
  logic [TO_CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;

  logic                expire;
  logic [MaxLanes-1:0] dec_full;
  logic                unused_dec;

  assign dec_full   = onehot_decode(MaxIdxW'(in_idx));
  assign unused_dec = ^dec_full[MaxLanes-1:N];

  hold_timer #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q != StGrant),
    .enable (state_q == StGrant),
    .expire (expire)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    timeout_d     = 1'b0;
    timeout_cnt_d = timeout_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          grant_idx_d = in_idx;
          grant_d     = dec_full[N-1:0];
          state_d     = StGrant;
        end
      end
      StGrant: begin
        // Only the held lane's done counts, and it beats a simultaneous expiry.
        if (done[grant_idx_q]) begin
          grant_d = '0;
          state_d = StGap;
        end else if (expire) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          if (timeout_cnt_q != '1) begin
            timeout_cnt_d = timeout_cnt_q + 1'b1;
          end
          state_d = StGap;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
    grant_valid_d = |grant_d;
    busy_d        = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      timeout_q     <= timeout_d;
      busy_q        <= busy_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign timeout     = timeout_q;
  assign busy        = busy_q;
  assign timeout_cnt = timeout_cnt_q;

endmodule
